// File: rtl/ppu_pkg.sv
// Shared PPU definitions: palette geometry, screen size, PPUMASK bit positions.
// Also provides the CPU-side palette mirror helper.
package ppu_pkg;

    localparam int          PAL_ENTRIES  = 32;
    localparam logic [4:0]  PAL_BACKDROP = 5'd0;
    localparam logic [5:0]  PAL_PAGE     = 6'h3F;
    localparam int          SCREEN_W     = 256;
    localparam int          SCREEN_H     = 240;

    localparam logic [7:0]  X_LAST = 8'(SCREEN_W - 1);
    localparam logic [7:0]  Y_LAST = 8'(SCREEN_H - 1);

    localparam int MASK_GRAY     = 0;
    localparam int MASK_BG_EN    = 3;
    localparam int MASK_SPR_EN   = 4;
    localparam int MASK_EMPH_LSB = 5;

    localparam logic [5:0] GRAY_MASK = 6'h30;

    // Stage 1: resolved lookup address plus the mask bits sampled with the pixel.
    typedef struct packed {
        logic       vld;
        logic [4:0] addr;
        logic       gray;
        logic [2:0] emph;
    } s1_t;

    typedef struct packed {
        logic       vld;
        logic [5:0] color;
        logic [2:0] emph;
        logic [7:0] x;
        logic [7:0] y;
        logic       frame_start;
        logic       line_end;
    } pix_t;

    // Sprite backdrop slots $10/$14/$18/$1C alias the background ones.
    function automatic logic [4:0] pal_mirror(input logic [4:0] addr);
        logic [4:0] res;
        res = addr;
        if (addr[4] && (addr[1:0] == 2'b00)) begin
            res = {1'b0, addr[3:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/nes_rgb_lut.sv
// Combinational {emphasis, colour} -> RGB888 ROM; only built with PPU_PAL_RGB_EN.
// Emphasis dims the non-emphasised channels to 3/4.
`ifdef PPU_PAL_RGB_EN
module nes_rgb_lut (
    input  logic [2:0]  emph_i,
    input  logic [5:0]  color_i,
    output logic [23:0] rgb_o
);

    logic [23:0] base;

    function automatic logic [7:0] dim(input logic [7:0] c, input logic en);
        return en ? (c - {2'b00, c[7:2]}) : c;
    endfunction

    always_comb begin
        base = 24'h000000;
        case (color_i)
            6'h00: base = 24'h666666; 6'h01: base = 24'h002A88; 6'h02: base = 24'h1412A7; 6'h03: base = 24'h3B00A4;
            6'h04: base = 24'h5C007E; 6'h05: base = 24'h6E0040; 6'h06: base = 24'h6C0600; 6'h07: base = 24'h561D00;
            6'h08: base = 24'h333500; 6'h09: base = 24'h0B4800; 6'h0A: base = 24'h005200; 6'h0B: base = 24'h004F08;
            6'h0C: base = 24'h00404D; 6'h0D: base = 24'h000000; 6'h0E: base = 24'h000000; 6'h0F: base = 24'h000000;
            6'h10: base = 24'hADADAD; 6'h11: base = 24'h155FD9; 6'h12: base = 24'h4240FF; 6'h13: base = 24'h7527FE;
            6'h14: base = 24'hA01ACC; 6'h15: base = 24'hB71E7B; 6'h16: base = 24'hB53120; 6'h17: base = 24'h994E00;
            6'h18: base = 24'h6B6D00; 6'h19: base = 24'h388700; 6'h1A: base = 24'h0C9300; 6'h1B: base = 24'h008F32;
            6'h1C: base = 24'h007C8D; 6'h1D: base = 24'h000000; 6'h1E: base = 24'h000000; 6'h1F: base = 24'h000000;
            6'h20: base = 24'hFFFEFF; 6'h21: base = 24'h64B0FF; 6'h22: base = 24'h9290FF; 6'h23: base = 24'hC676FF;
            6'h24: base = 24'hF36AFF; 6'h25: base = 24'hFE6ECC; 6'h26: base = 24'hFE8170; 6'h27: base = 24'hEA9E22;
            6'h28: base = 24'hBCBE00; 6'h29: base = 24'h88D800; 6'h2A: base = 24'h5CE430; 6'h2B: base = 24'h45E082;
            6'h2C: base = 24'h48CDDE; 6'h2D: base = 24'h4F4F4F; 6'h2E: base = 24'h000000; 6'h2F: base = 24'h000000;
            6'h30: base = 24'hFFFEFF; 6'h31: base = 24'hC0DFFF; 6'h32: base = 24'hD3D2FF; 6'h33: base = 24'hE8C8FF;
            6'h34: base = 24'hFBC2FF; 6'h35: base = 24'hFEC4EA; 6'h36: base = 24'hFECCC5; 6'h37: base = 24'hF7D8A5;
            6'h38: base = 24'hE4E594; 6'h39: base = 24'hCFEF96; 6'h3A: base = 24'hBDF4AB; 6'h3B: base = 24'hB3F3CC;
            6'h3C: base = 24'hB5EBF2; 6'h3D: base = 24'hB8B8B8; 6'h3E: base = 24'h000000; 6'h3F: base = 24'h000000;
            default: base = 24'h000000;
        endcase
    end

    // emph_i[0]=red, [1]=green, [2]=blue.
    always_comb begin
        rgb_o = {dim(base[23:16], (emph_i != 3'b000) && !emph_i[0]),
                 dim(base[15:8],  (emph_i != 3'b000) && !emph_i[1]),
                 dim(base[7:0],   (emph_i != 3'b000) && !emph_i[2])};
    end

endmodule
`endif

// File: rtl/ppu_palette_out.sv
// PPU pixel output: palette RAM lookup, grayscale/emphasis, x/y tagging; latency 2 (3 with
// PPU_PAL_RGB_EN, which adds an RGB888 stage); 1 pixel/cycle, no backpressure.
module ppu_palette_out
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        px_en,
    input  logic [4:0]  palette_idx,
    input  logic [7:0]  ppumask,
    input  logic        vblank,
    input  logic [13:0] vram_addr,
    input  logic [4:0]  cpu_addr,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [5:0]  cpu_din,
    output logic [5:0]  cpu_dout,
    output logic        px_valid,
    output logic [5:0]  px_color,
    output logic [2:0]  px_emph,
    output logic [7:0]  px_x,
    output logic [7:0]  px_y,
    output logic        frame_start,
    output logic        line_end,
    output logic [23:0] px_rgb
);

    logic [5:0] pal_mem [PAL_ENTRIES];
    logic [4:0] cpu_idx;
    logic [4:0] lookup_addr;
    logic [5:0] cpu_dout_q;
    s1_t        s1_d, s1_q;
    pix_t       s2_d, s2_q, out_q;
    logic [7:0] x_cnt_d, x_cnt_q;
    logic [7:0] y_cnt_d, y_cnt_q;
    logic       unused_ok;

    assign unused_ok = ^{vram_addr[7:5], ppumask[2:1]};
    assign cpu_idx   = pal_mirror(cpu_addr);

    // No reset on the RAM; readers sample before the write lands (read-first).
    always_ff @(posedge clk) begin
        if (cpu_wr) begin
            pal_mem[cpu_idx] <= cpu_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_dout_q <= '0;
        end else if (cpu_rd) begin
            cpu_dout_q <= pal_mem[cpu_idx];
        end
    end
    assign cpu_dout = cpu_dout_q;

    // With rendering off and v pointing into palette space, the backdrop shows that entry.
    always_comb begin
        lookup_addr = palette_idx;
        if (palette_idx[1:0] == 2'b00) begin
            lookup_addr = PAL_BACKDROP;
            if ((ppumask[MASK_SPR_EN:MASK_BG_EN] == 2'b00) && (vram_addr[13:8] == PAL_PAGE)) begin
                lookup_addr = pal_mirror(vram_addr[4:0]);
            end
        end
    end

    always_comb begin
        s1_d      = '0;
        s1_d.vld  = px_en;
        s1_d.addr = lookup_addr;
        s1_d.gray = ppumask[MASK_GRAY];
        s1_d.emph = ppumask[MASK_EMPH_LSB +: 3];
    end

    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (vblank) begin
            x_cnt_d = '0;
            y_cnt_d = '0;
        end else if (s1_q.vld) begin
            x_cnt_d = x_cnt_q + 8'd1;
            if ((x_cnt_q == X_LAST) && (y_cnt_q != Y_LAST)) begin
                y_cnt_d = y_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        s2_d             = '0;
        s2_d.vld         = s1_q.vld;
        s2_d.color       = pal_mem[s1_q.addr] & (s1_q.gray ? GRAY_MASK : 6'h3F);
        s2_d.emph        = s1_q.emph;
        s2_d.x           = x_cnt_q;
        s2_d.y           = y_cnt_q;
        s2_d.frame_start = s1_q.vld && (x_cnt_q == 8'd0) && (y_cnt_q == 8'd0);
        s2_d.line_end    = s1_q.vld && (x_cnt_q == X_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
        end
    end

`ifdef PPU_PAL_RGB_EN
    logic [23:0] rgb_lut;
    logic [23:0] rgb_q;
    pix_t        s3_q;

    nes_rgb_lut u_rgb_lut (
        .emph_i  (s2_q.emph),
        .color_i (s2_q.color),
        .rgb_o   (rgb_lut)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_q  <= '0;
            rgb_q <= '0;
        end else begin
            s3_q  <= s2_q;
            rgb_q <= rgb_lut;
        end
    end

    assign out_q  = s3_q;
    assign px_rgb = rgb_q;
`else
    assign out_q  = s2_q;
    assign px_rgb = '0;
`endif

    assign px_valid    = out_q.vld;
    assign px_color    = out_q.color;
    assign px_emph     = out_q.emph;
    assign px_x        = out_q.x;
    assign px_y        = out_q.y;
    assign frame_start = out_q.frame_start;
    assign line_end    = out_q.line_end;

endmodule

// File: tb/tb_ppu_palette_out.sv
// Directed bench for ppu_palette_out: palette writes/reads, lookup rules, collisions, frame counters.
module tb_ppu_palette_out;

`ifdef PPU_PAL_RGB_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int NPIX = 256 * 241;

    logic        clk = 1'b0;
    logic        rst;
    logic        px_en;
    logic [4:0]  palette_idx;
    logic [7:0]  ppumask;
    logic        vblank;
    logic [13:0] vram_addr;
    logic [4:0]  cpu_addr;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [5:0]  cpu_din;
    logic [5:0]  cpu_dout;
    logic        px_valid;
    logic [5:0]  px_color;
    logic [2:0]  px_emph;
    logic [7:0]  px_x;
    logic [7:0]  px_y;
    logic        frame_start;
    logic        line_end;
    logic [23:0] px_rgb;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ppu_palette_out dut (
        .clk         (clk),
        .rst         (rst),
        .px_en       (px_en),
        .palette_idx (palette_idx),
        .ppumask     (ppumask),
        .vblank      (vblank),
        .vram_addr   (vram_addr),
        .cpu_addr    (cpu_addr),
        .cpu_wr      (cpu_wr),
        .cpu_rd      (cpu_rd),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .px_valid    (px_valid),
        .px_color    (px_color),
        .px_emph     (px_emph),
        .px_x        (px_x),
        .px_y        (px_y),
        .frame_start (frame_start),
        .line_end    (line_end),
        .px_rgb      (px_rgb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [5:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_wr   = 1'b1;
        tick();
        cpu_wr   = 1'b0;
    endtask

    task automatic cpu_read(input logic [4:0] a);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        tick();
        cpu_rd   = 1'b0;
    endtask

    // Single pixel; returns with its output visible.
    task automatic pixel1(input logic [4:0] idx);
        px_en       = 1'b1;
        palette_idx = idx;
        tick();
        px_en       = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    initial begin
        int k, coord_err, le_err, col_err, fs_cnt, le_cnt, last_y;
        int exp_x, exp_y;

        rst = 1'b1; px_en = 1'b0; palette_idx = '0; ppumask = 8'h18; vblank = 1'b0;
        vram_addr = '0; cpu_addr = '0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_din = '0;
        repeat (3) tick();
        check("rst_px_valid", 32'(px_valid), 0);
        check("rst_px_color", 32'(px_color), 0);
        check("rst_px_emph", 32'(px_emph), 0);
        check("rst_px_x", 32'(px_x), 0);
        check("rst_px_y", 32'(px_y), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_line_end", 32'(line_end), 0);
        check("rst_cpu_dout", 32'(cpu_dout), 0);
        check("rst_px_rgb", 32'(px_rgb), 0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) cpu_write(5'(i), 6'h00);

        // Basic lookup; emphasis travels with its own pixel.
        cpu_write(5'h00, 6'h0F);
        cpu_write(5'h05, 6'h16);
        px_en = 1'b1; palette_idx = 5'd5; ppumask = 8'hB8;
        tick();
        palette_idx = 5'd4; ppumask = 8'h18;
        tick();
        px_en = 1'b0;
        repeat (LAT - 2) tick();
        check("t1_a_valid", 32'(px_valid), 1);
        check("t1_a_color", 32'(px_color), 32'h16);
        check("t1_a_emph", 32'(px_emph), 5);
        tick();
        check("t1_b_valid", 32'(px_valid), 1);
        check("t1_b_color", 32'(px_color), 32'h0F);
        check("t1_b_emph", 32'(px_emph), 0);
        tick();
        check("t1_idle_valid", 32'(px_valid), 0);

        // $3F10 aliases $3F00.
        cpu_write(5'h10, 6'h21);
        cpu_read(5'h00);
        check("t2_mirror_rd", 32'(cpu_dout), 32'h21);
        tick();
        check("t2_dout_hold", 32'(cpu_dout), 32'h21);
        pixel1(5'h10);
        check("t2_px_idx10", 32'(px_color), 32'h21);

        // Grayscale affects pixels only.
        ppumask = 8'h19;
        pixel1(5'd5);
        check("t3_gray", 32'(px_color), 32'h10);
        cpu_read(5'd5);
        check("t3_cpu_raw", 32'(cpu_dout), 32'h16);
        ppumask = 8'h18;

        // Backdrop override.
        cpu_write(5'd7, 6'h2A);
        cpu_write(5'd4, 6'h05);
        ppumask = 8'h00; vram_addr = 14'h3F07;
        pixel1(5'd0);
        check("t4_override", 32'(px_color), 32'h2A);
        vram_addr = 14'h3F14;
        pixel1(5'd0);
        check("t4_override_mirror", 32'(px_color), 32'h05);
        vram_addr = 14'h2F07;
        pixel1(5'd0);
        check("t4_not_pal_page", 32'(px_color), 32'h21);
        ppumask = 8'h18; vram_addr = 14'h3F07;
        pixel1(5'd0);
        check("t4_render_on", 32'(px_color), 32'h21);
        vram_addr = '0;

        // Write lands in the cycle pixel A reads the RAM.
        cpu_write(5'd3, 6'h01);
        px_en = 1'b1; palette_idx = 5'd3;
        tick();
        cpu_addr = 5'd3; cpu_din = 6'h30; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0; px_en = 1'b0;
        repeat (LAT - 2) tick();
        check("t5_collide_old", 32'(px_color), 32'h01);
        tick();
        check("t5_collide_new", 32'(px_color), 32'h30);

        cpu_addr = 5'd3; cpu_din = 6'h11; cpu_rd = 1'b1; cpu_wr = 1'b1;
        tick();
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        check("t6_rdwr_old", 32'(cpu_dout), 32'h30);
        cpu_read(5'd3);
        check("t6_rdwr_new", 32'(cpu_dout), 32'h11);
        cpu_write(5'h1C, 6'h3C);
        cpu_read(5'h0C);
        check("t6_mirror_1c", 32'(cpu_dout), 32'h3C);

        // Reset with pixels in flight.
        px_en = 1'b1; palette_idx = 5'd5;
        tick();
        tick();
        rst = 1'b1; px_en = 1'b0;
        tick();
        check("t7_rst_valid", 32'(px_valid), 0);
        rst = 1'b0;
        repeat (LAT) tick();
        check("t7_dropped", 32'(px_valid), 0);
        pixel1(5'd5);
        check("t7_x", 32'(px_x), 0);
        check("t7_y", 32'(px_y), 0);
        check("t7_frame_start", 32'(frame_start), 1);
        check("t7_line_end", 32'(line_end), 0);

        // Full frame plus one extra line to see y hold at 239.
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        k = 0; coord_err = 0; le_err = 0; col_err = 0; fs_cnt = 0; le_cnt = 0; last_y = -1;
        for (int c = 0; c < NPIX + LAT; c++) begin
            px_en = (c < NPIX);
            palette_idx = 5'd5;
            tick();
            if (px_valid) begin
                exp_x = k % 256;
                exp_y = (k / 256 > 239) ? 239 : k / 256;
                if ((int'(px_x) != exp_x) || (int'(px_y) != exp_y)) coord_err++;
                if (line_end !== (exp_x == 255)) le_err++;
                if (px_color !== 6'h16) col_err++;
                if (frame_start === 1'b1) fs_cnt++;
                if (line_end === 1'b1) le_cnt++;
                if (k == 256 * 240 - 1) last_y = int'(px_y);
                k++;
            end
        end
        px_en = 1'b0;
        check("t8_pixels", 32'(k), 32'(NPIX));
        check("t8_coord_err", 32'(coord_err), 0);
        check("t8_line_end_pos", 32'(le_err), 0);
        check("t8_color_err", 32'(col_err), 0);
        check("t8_frame_start_cnt", 32'(fs_cnt), 1);
        check("t8_line_end_cnt", 32'(le_cnt), 241);
        check("t8_last_line_y", 32'(last_y), 239);

        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        pixel1(5'd5);
        check("t9_x_after_vblank", 32'(px_x), 0);
        check("t9_y_after_vblank", 32'(px_y), 0);
        check("t9_frame_start", 32'(frame_start), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ppu_palette_out.md
# ppu_palette_out

Downstream pixel-output stage of the PPU. It consumes the 5-bit `palette_idx` and `px_en` stream produced by the renderer. It owns the 32-entry palette RAM and resolves each pixel to a 6-bit NES colour with grayscale and emphasis applied. It tags each output pixel with x/y coordinates and frame/line markers for the video encoder, and serves CPU palette accesses arriving via PPUDATA ($3F00–$3FFF).

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- px_en  in  1  renderer pixel strobe, one pixel per cycle
- palette_idx  in  5  renderer palette index; bit4 = sprite
- ppumask  in  8  bit0 grayscale; bits4:3 render enables; bits7:5 emphasis
- vblank  in  1  renderer vblank flag
- vram_addr  in  14  current PPU v register, used for backdrop override
- cpu_addr  in  5  palette address (PPU addr[4:0])
- cpu_wr  in  1  palette write strobe
- cpu_rd  in  1  palette read strobe
- cpu_din  in  6  write data
- cpu_dout  out  6  read data, registered
- px_valid  out  1  output pixel valid
- px_color  out  6  resolved NES colour
- px_emph  out  3  emphasis bits, aligned with px_color
- px_x  out  8  pixel column
- px_y  out  8  pixel row
- frame_start  out  1  first pixel of a frame (x=0, y=0)
- line_end  out  1  last pixel of a line (x=255)
- px_rgb  out  24  RGB888; present only with PPU_PAL_RGB_EN

## Operation
- Palette RAM: 32×6 bits, reset contents undefined. The bench must initialise it before checking colours.
- CPU address mirror: addresses $10, $14, $18 and $1C map to $00, $04, $08 and $0C. All other addresses are direct.
- Pixel lookup address:
  - If idx[1:0]==0, use entry 0 (universal backdrop).
  - Otherwise use idx directly.
- Backdrop override: when ppumask[4:3]==0 and vram_addr[13:8]==6'h3F, the lookup uses CPU-mirrored vram_addr[4:0] instead of entry 0.
- Grayscale: when ppumask[0]=1, px_color = colour & 6'h30.
- ppumask is sampled in stage 1, together with its pixel.
- CPU read: cpu_dout is updated one cycle after cpu_rd with the raw entry. No grayscale is applied to CPU reads. cpu_dout holds otherwise.
- CPU write: the entry is updated at the clock edge where cpu_wr is high.
- Same-cycle collision (pixel lookup and write to the same entry): the pixel gets the old value (read-first). The following pixel gets the new value.
- Simultaneous cpu_rd and cpu_wr to the same address: cpu_dout returns the old value.
- Coordinate counters:
  - x increments on each px_valid and wraps 255→0. Each wrap increments y.
  - y holds at 239; it does not wrap.
  - While vblank=1, x and y are forced to 0.
- frame_start = px_valid & x==0 & y==0.
- line_end = px_valid & x==255.

## Timing
- Two-stage pipeline, latency 2:
  - Stage 1 registers the address, mask bits and valid.
  - Stage 2 registers the RAM read data plus grayscale.
- px_en at cycle N → px_valid at cycle N+2. Throughput is 1 pixel/cycle with no stalls.
- px_x/px_y/frame_start/line_end are aligned with px_valid.
- Reset values: px_valid=0, px_color=0, px_emph=0, px_x=0, px_y=0, frame_start=0, line_end=0, cpu_dout=0, px_rgb=0.
- All pipeline valid bits are cleared on reset.
- Reset mid-line drops in-flight pixels. Counting restarts at (0,0).

## Configuration
- PPU_PAL_RGB_EN:
  - Defined: a third pipeline stage converts px_color+px_emph to px_rgb through the LUT. All outputs are then delayed by one more cycle (latency 3), keeping everything aligned.
  - Undefined: px_rgb is tied to 0 and latency is 2.

## Structure
- Shared ppu package:
  - PAL_ENTRIES=32, PAL_BACKDROP=0, PAL_PAGE=6'h3F, SCREEN_W=256, SCREEN_H=240
  - ppumask bit-position constants
  - function pal_mirror(addr)
- Sub-module nes_rgb_lut: combinational 512-entry ROM ({emph, colour} → RGB888), instantiated only under PPU_PAL_RGB_EN.

## Test plan
- Write $3F00=0x0F and $3F05=0x16; drive px_en with idx 5 then idx 4 → px_color 0x16, then 0x0F, at N+2 and N+3.
- Write $3F10=0x21, then read $3F00 → cpu_dout=0x21. Pixel idx 0x10 → 0x21.
- Set ppumask[0]=1 with entry 0x16 → px_color 0x10. cpu_dout still reads 0x16.
- ppumask[4:3]=0, vram_addr=0x3F07, entry 7=0x2A, idx 0 → px_color 0x2A.
- 256×240 continuous px_en, then vblank → frame_start once at first pixel; line_end on every 256th pixel; y=239 on last line; x,y=0 after vblank.
- Write entry 3=0x30 in the same cycle as a pixel read of idx 3 (old value 0x01) → that pixel outputs 0x01; the next pixel outputs 0x30.
